// File: rtl/gcd_binary.sv
// Binary (Stein) GCD coprocessor with a start/done handshake, abort, busy flag and iteration counter.
// Each RUN cycle performs one shift or one subtract-and-shift; common powers of two are restored at completion.
module gcd_binary #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] iter_count
);

    localparam int unsigned K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] diff_ab;
    logic [WIDTH-1:0] diff_ba;
    logic [WIDTH-1:0] result_next;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_next;
    logic [CNT_W-1:0] iter_next;
    logic             done_next;
    logic             busy_next;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a          <= '0;
            b          <= '0;
            k          <= '0;
            result     <= '0;
            iter_count <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            a          <= a_next;
            b          <= b_next;
            k          <= k_next;
            result     <= result_next;
            iter_count <= iter_next;
            done       <= done_next;
            busy       <= busy_next;
        end
    end

    // Next-state and datapath decisions; abort outranks completion, zero tests outrank parity steps
    always_comb begin
        state_next  = state;
        a_next      = a;
        b_next      = b;
        k_next      = k;
        result_next = result;
        iter_next   = iter_count;
        done_next   = done;
        diff_ab     = a - b;
        diff_ba     = b - a;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    a_next     = opa;
                    b_next     = opb;
                    k_next     = '0;
                    iter_next  = '0;
                    done_next  = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (a == '0) begin
                    result_next = b << k;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else if (b == '0) begin
                    result_next = a << k;
                    done_next   = 1'b1;
                    state_next  = DONE;
                end else begin
                    if (!a[0] && !b[0]) begin
                        a_next = a >> 1;
                        b_next = b >> 1;
                        k_next = k + K_W'(1);
                    end else if (!a[0]) begin
                        a_next = a >> 1;
                    end else if (!b[0]) begin
                        b_next = b >> 1;
                    end else if (a >= b) begin
                        a_next = diff_ab >> 1;
                    end else begin
                        b_next = diff_ba >> 1;
                    end
                    if (iter_count != '1) begin
                        iter_next = iter_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_gcd_binary.sv
// Scoreboard bench for gcd_binary: stimulus pushes model results, a monitor checks each done rising edge.
module tb_gcd_binary;

    localparam int unsigned W  = 16;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic [CW-1:0] iter_count;

    typedef struct {
        longint unsigned res;
        int              iters;
        int              acc;
    } exp_t;

    exp_t            sb[$];
    int              cyc = 0;
    int              n_checks = 0;
    int              n_fail = 0;
    longint unsigned last_res = 0;

    gcd_binary #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .iter_count (iter_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference GCD by the Euclidean remainder method
    function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
        longint unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Number of counted steps the binary method takes on (x, y)
    function automatic int ref_iters(input longint unsigned x, input longint unsigned y);
        int n = 0;
        while (x != 0 && y != 0) begin
            if (x % 2 == 0 && y % 2 == 0) begin
                x = x / 2;
                y = y / 2;
            end else if (x % 2 == 0) begin
                x = x / 2;
            end else if (y % 2 == 0) begin
                y = y / 2;
            end else if (x >= y) begin
                x = (x - y) / 2;
            end else begin
                y = (y - x) / 2;
            end
            n++;
        end
        return n;
    endfunction

    // Monitor: each rising done must match the oldest outstanding request
    initial begin
        logic done_q = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (resetn && done && !done_q) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("result", result, e.res);
                    check("iter_count", iter_count, longint'(e.iters));
                    check("latency", longint'(cyc - e.acc), longint'(e.iters + 1));
                    check("latency_bound", longint'((cyc - e.acc) <= 2 * W + 1), 1);
                end
            end
            done_q = done;
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit mid_start, input bit abort_too);
        exp_t e;
        bit   got;
        start   = 1'b1;
        abort   = abort_too;
        opa     = x;
        opb     = y;
        e.res   = ref_gcd(longint'(x), longint'(y));
        e.iters = ref_iters(longint'(x), longint'(y));
        e.acc   = cyc + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        opa   = W'($urandom);
        opb   = W'($urandom);
        check("busy_after_accept", busy, 1);
        check("done_cleared", done, 0);
        if (mid_start) begin
            start = 1'b1;
            opa   = W'(100);
            opb   = W'(75);
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 3 * W && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        check("done_timeout", got, 1);
        check("busy_at_done", busy, 0);
        // abort in DONE is ignored; outputs hold
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        check("done_sticky", done, 1);
        check("result_held", result, e.res);
        check("iter_held", iter_count, longint'(e.iters));
        last_res = e.res;
    endtask

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           s;
        resetn = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        opa    = '0;
        opb    = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_iter", iter_count, 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);

        do_op(W'(48), W'(18), 1'b1, 1'b0);
        check("t1_result", result, 6);
        do_op(W'(0), W'(5), 1'b0, 1'b0);
        do_op(W'(0), W'(0), 1'b0, 1'b0);
        do_op(W'(17), W'(17), 1'b0, 1'b0);
        do_op(W'(64), W'(32), 1'b0, 1'b0);
        check("t3_result", result, 32);
        do_op(W'(255), W'(1), 1'b0, 1'b0);
        check("t3_iter", iter_count, 8);

        // Abort at the third edge after accept
        start = 1'b1;
        opa   = W'(48);
        opb   = W'(18);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, last_res);
        check("abort_iter", iter_count, 2);
        repeat (4) @(negedge clk);
        check("abort_done_stays", done, 0);

        // Short reset pulse mid-computation
        @(negedge clk);
        start = 1'b1;
        opa   = W'(48);
        opb   = W'(18);
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_iter", iter_count, 0);
        #1 resetn = 1'b1;
        last_res = 0;
        @(negedge clk);
        do_op(W'(48), W'(18), 1'b0, 1'b1);
        check("t5_result", result, 6);

        // Random sweep
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    x = W'($urandom);
                    y = W'($urandom);
                end
                1: begin
                    s = $urandom_range(0, 6);
                    x = W'($urandom_range(1, 400) << s);
                    y = W'($urandom_range(1, 400) << s);
                end
                2: begin
                    x = ($urandom_range(0, 1) == 1) ? W'(0) : W'($urandom);
                    y = (x != 0) ? W'(0) : W'($urandom);
                end
                default: begin
                    x = W'($urandom_range(0, 20));
                    y = W'($urandom_range(0, 20));
                end
            endcase
            do_op(x, y, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
